// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single unified memory port between instruction fetch (IF)
//   and the data-memory stage (DM). Exactly one transaction is outstanding
//   at a time. DM has default priority. A saturating starvation counter
//   forces an IF win after STARVE_MAX consecutive DM wins taken while IF
//   was waiting.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   if_req/if_addr      IF read request (held until if_gnt)
//   if_gnt              one-cycle pulse, IF request captured
//   if_rvalid/if_rdata  IF read completion pulse and held read data
//   dm_req/dm_we/dm_addr/dm_wdata  DM request (held until dm_gnt)
//   dm_gnt              one-cycle pulse, DM request captured
//   dm_rvalid/dm_rdata  DM completion pulse and held read data (0 on writes)
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, stable until mem_ack
//   mem_ack/mem_rdata   memory completion and read data
//   mux_sel             address/data port-mux select, 0=IF 1=DM
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          mux_sel
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t        r_state,      w_state_nxt;
  logic [7:0]    r_starve_cnt, w_starve_nxt;
  logic          r_mux_sel,    w_mux_sel_nxt;
  logic          r_mem_we,     w_mem_we_nxt;
  logic [AW-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [DW-1:0] r_mem_wdata,  w_mem_wdata_nxt;
  logic          r_if_gnt,     w_if_gnt_nxt;
  logic          r_dm_gnt,     w_dm_gnt_nxt;
  logic          r_if_rvalid,  w_if_rvalid_nxt;
  logic          r_dm_rvalid,  w_dm_rvalid_nxt;
  logic [DW-1:0] r_if_rdata,   w_if_rdata_nxt;
  logic [DW-1:0] r_dm_rdata,   w_dm_rdata_nxt;
  logic          w_if_forced;
  logic          w_dm_wins;

  // IF is forced through only when it is waiting and DM has used up its
  // allowance of consecutive wins.
  assign w_if_forced = if_req && (r_starve_cnt == STARVE_LIM);
  assign w_dm_wins   = dm_req && !w_if_forced;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_mux_sel    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_gnt     <= 1'b0;
      r_dm_gnt     <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_mux_sel    <= w_mux_sel_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_if_gnt     <= w_if_gnt_nxt;
      r_dm_gnt     <= w_dm_gnt_nxt;
      r_if_rvalid  <= w_if_rvalid_nxt;
      r_dm_rvalid  <= w_dm_rvalid_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_dm_rdata   <= w_dm_rdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_starve_nxt    = r_starve_cnt;
    w_mux_sel_nxt   = r_mux_sel;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_gnt_nxt    = 1'b0;
    w_dm_gnt_nxt    = 1'b0;
    w_if_rvalid_nxt = 1'b0;
    w_dm_rvalid_nxt = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_dm_rdata_nxt  = r_dm_rdata;

    case (r_state)
      S_IDLE: begin
        if (if_req || dm_req) begin
          w_state_nxt   = S_BUSY;
          w_mux_sel_nxt = w_dm_wins;
          if (w_dm_wins) begin
            w_dm_gnt_nxt    = 1'b1;
            w_mem_we_nxt    = dm_we;
            w_mem_addr_nxt  = dm_addr;
            w_mem_wdata_nxt = dm_wdata;
            // Only DM wins over a waiting IF count toward starvation.
            if (!if_req) begin
              w_starve_nxt = '0;
            end else if (r_starve_cnt != STARVE_LIM) begin
              w_starve_nxt = r_starve_cnt + 8'd1;
            end
          end else begin
            w_if_gnt_nxt    = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = if_addr;
            w_mem_wdata_nxt = '0;
            w_starve_nxt    = '0;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          w_state_nxt = S_IDLE;
          // mux_sel still names the owner of the finishing transaction.
          if (r_mux_sel) begin
            w_dm_rvalid_nxt = 1'b1;
            w_dm_rdata_nxt  = r_mem_we ? '0 : mem_rdata;
          end else begin
            w_if_rvalid_nxt = 1'b1;
            w_if_rdata_nxt  = mem_rdata;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign mem_req   = (r_state == S_BUSY);
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mux_sel   = r_mux_sel;
  assign if_gnt    = r_if_gnt;
  assign dm_gnt    = r_dm_gnt;
  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;

endmodule
